input_pack_reg: RTL
===================

# input_pack_reg

Packs bit-fusion lane data back into dense 32-bit buffer words; it is the write-side inverse of the input MUX register, which spreads one buffer word over 1, 2 or 4 replicated 32-bit beats. It sits between the fusion-array result/readback path and the buffer write port. It reassembles one word from 1, 2 or 4 beats according to `weight_bitwidth`, then presents the word with a valid/ready handshake. It also supports a zero-padded flush of a partial word.

## Interface
- No parameters; data width is fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `weight_bitwidth`  in  2  packing mode: 00 = 1 beat/word, 01 = 2 beats/word, 10/11 = 4 beats/word
- `in_valid`  in  1  `data_in` carries a beat
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `data_in`  in  32  replicated lane beat
- `flush`  in  1  close the current partial word, padding missing fields with 0
- `out_valid`  out  1  `packed_data` holds a completed word
- `out_ready`  in  1  downstream accepts the word
- `packed_data`  out  32  reassembled buffer word
- `phase`  out  2  index of the next expected beat within the current word

## Operation
- Beat k of a word lands in the accumulator as follows:
  - Mode 00: `data_in` is the word.
  - Mode 01, k∈{0,1}: for j=0..3, acc[16k+2j+1:16k+2j] = data_in[8j+1:8j] (even 4-bit group 2j), and acc[16k+2j+9:16k+2j+8] = data_in[8j+5:8j+4] (odd group 2j+1).
  - Mode 1x, k∈{0..3}: for g=0..3, acc[8k+2g+1:8k+2g] = data_in[8g+1:8g].
- Only the lowest 2-bit copy in each group is used. Replica bits are ignored and are not checked.
- Mode latch:
  - `weight_bitwidth` is sampled on the accepted beat with `phase`=0.
  - Changes during phases 1..3 are ignored until the word completes or is flushed.
- Phase counter:
  - Increments on each accepted beat.
  - On the final beat (phase = beats−1) it returns to 0 and the word transfers to the output register.
- Accumulator handling:
  - Cleared to 0 when a word starts.
  - Bits that no beat wrote remain 0.
- Flush:
  - Acts only when `in_ready`=1 and `phase`≠0, or when the beat accepted in the same cycle leaves the word incomplete.
  - The accumulator, including any same-cycle beat, moves to the output register and `phase` returns to 0.
  - Flush with `phase`=0 and no beat: no effect.
  - Flush on the same cycle as a final beat: completes normally, with no extra word.
- `in_ready` = !`out_valid` || `out_ready`. The block stalls only while a completed word is held and not drained.
- Output register:
  - Loads on completion or flush.
  - `out_valid` clears on `out_valid && out_ready` when no new word loads in the same cycle.
  - Drain and load in the same cycle: new word, `out_valid` stays 1.
- Reset values: `out_valid`=0, `packed_data`=0, `phase`=0, accumulator=0, latched mode=00, `in_ready`=1.
- Reset mid-word discards the partial word and any held output.

## Timing
- Latency: `packed_data`/`out_valid` are valid the cycle after the final (or flushed) beat is accepted.
- Throughput: one beat per cycle with `out_ready` held at 1. Words are back-to-back with no bubble.
- `packed_data` is stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is combinational from `out_valid` and `out_ready`. All other outputs are registered.

## Test plan
- Mode 00: beat 0xDEADBEEF → next cycle `out_valid`=1, `packed_data`=0xDEADBEEF, `phase`=0.
- Mode 01:
  - Beats 0x0F0F0F0F then 0x00000000 → `packed_data`=0x000000FF, one cycle after beat 2.
  - Beats 0x00000000 then 0x0F0F0F0F → 0x00FF0000.
- Mode 10: four beats of 0xFFAA5500 → 0xE4E4E4E4. Switching mode to 00 after beat 1 has no effect on the result.
- Flush: mode 11, beat 0xFFAA5500, then `flush` with `in_valid`=0 → 0x000000E4. Beat plus flush in the same cycle gives the same result.
- Backpressure:
  - Hold `out_ready`=0 after a mode-00 word → `in_ready`=0, `packed_data` stable for 5 cycles.
  - Raise `out_ready` with a new beat presented → new word appears next cycle, `out_valid` stays 1.
- Reset after 2 of 4 mode-10 beats → `phase`=0, `out_valid`=0. The next 4 beats form a clean word with no leftover fields.

Source files
------------

// File: rtl/input_pack_reg.sv
// rtl/input_pack_reg.sv - reassembles 1/2/4 replicated lane beats into dense 32-bit buffer words
module input_pack_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  weight_bitwidth,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] packed_data,
    output logic [1:0]  phase
);

    logic [1:0]  phase_q, phase_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] acc_q, acc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] packed_q, packed_d;

    logic        accept;
    logic        word_start;
    logic        last_beat;
    logic        do_flush;
    logic        load;
    logic [1:0]  eff_mode;
    logic [1:0]  last_phase;
    logic [15:0] half_bits;
    logic [7:0]  quarter_bits;
    logic [31:0] beat_bits;
    logic [31:0] word_val;

    // Only the lowest 2-bit copy of each replicated 4-bit group carries data
    always_comb begin
        half_bits    = '0;
        quarter_bits = '0;
        for (int j = 0; j < 4; j++) begin
            half_bits[2*j +: 2]     = data_in[8*j +: 2];
            half_bits[2*j + 8 +: 2] = data_in[8*j + 4 +: 2];
            quarter_bits[2*j +: 2]  = data_in[8*j +: 2];
        end
    end

    always_comb begin
        in_ready   = !out_valid_q || out_ready;
        accept     = in_valid && in_ready;
        word_start = (phase_q == 2'd0);
        eff_mode   = word_start ? weight_bitwidth : mode_q;

        case (eff_mode)
            2'b00:   last_phase = 2'd0;
            2'b01:   last_phase = 2'd1;
            default: last_phase = 2'd3;
        endcase

        case (eff_mode)
            2'b00:   beat_bits = data_in;
            2'b01:   beat_bits = phase_q[0] ? {half_bits, 16'h0000} : {16'h0000, half_bits};
            default: beat_bits = {24'h000000, quarter_bits} << {phase_q, 3'b000};
        endcase

        word_val  = accept ? ((word_start ? 32'h0 : acc_q) | beat_bits) : acc_q;
        last_beat = accept && (phase_q == last_phase);
        // A flush only closes a word that actually holds at least one beat
        do_flush  = flush && in_ready && !last_beat && (!word_start || accept);
        load      = last_beat || do_flush;
    end

    always_comb begin
        phase_d     = phase_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        packed_d    = packed_q;

        if (accept && word_start) begin
            mode_d = weight_bitwidth;
        end

        if (load) begin
            phase_d     = 2'd0;
            acc_d       = 32'h0;
            out_valid_d = 1'b1;
            packed_d    = word_val;
        end else begin
            if (accept) begin
                phase_d = phase_q + 2'd1;
                acc_d   = word_val;
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= 2'd0;
            mode_q      <= 2'b00;
            acc_q       <= 32'h0;
            out_valid_q <= 1'b0;
            packed_q    <= 32'h0;
        end else begin
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            packed_q    <= packed_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign packed_data = packed_q;
    assign phase       = phase_q;

endmodule
